// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, ResultSrc
// selects and the LSU handshake state.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsuState_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobes/data replication, load
// extraction with sign/zero extension, and alignment checking.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byteOff,
  input  logic [XLEN-1:0] storeData,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] laneData,
  output logic [3:0]      strb,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  // The addressed byte/half is brought down to bit 0 before extension.
  assign shifted = rdata >> {byteOff, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    strb       = 4'b1111;
    laneData   = storeData;
    loadData   = shifted;
    case (funct3)
      F3_B, F3_BU: begin
        strb     = 4'b0001 << byteOff;
        laneData = {4{storeData[7:0]}};
        loadData = (funct3 == F3_B) ? {{(XLEN-8){shifted[7]}}, shifted[7:0]}
                                    : {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        misaligned = byteOff[0];
        strb       = 4'b0011 << byteOff;
        laneData   = {2{storeData[15:0]}};
        loadData   = (funct3 == F3_H) ? {{(XLEN-16){shifted[15]}}, shifted[15:0]}
                                      : {{(XLEN-16){1'b0}}, shifted[15:0]};
      end
      F3_W: begin
        misaligned = |byteOff;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: drives the data-memory valid/ready handshake, stalls the front
// of the pipeline while an access is outstanding, and owns the MEM/WB register.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            StallM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            misaligned_err,
  output logic            bus_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsuState_e        state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             access, misaligned, alignedAccess, timeoutFire;
  logic [XLEN-1:0]  laneData, loadData;
  logic [3:0]       strb;

  lsu_align #(.XLEN(XLEN)) align (
    .funct3    (funct3M),
    .byteOff   (ALUResultM[1:0]),
    .storeData (WriteDataM),
    .rdata     (mem_rdata),
    .laneData  (laneData),
    .strb      (strb),
    .loadData  (loadData),
    .misaligned(misaligned)
  );

  // Reset masks the request combinationally so nothing is issued that cycle.
  assign access        = MemWriteM | (ResultSrcM == RES_MEM);
  assign alignedAccess = access & ~misaligned & ~reset;
  assign timeoutFire   = alignedAccess & (state == WAIT) & (waitCnt == CNT_LAST) & ~mem_ready;

  assign mem_req   = alignedAccess;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[XLEN-1:2], 2'b00};
  assign mem_wdata = laneData;
  assign mem_wstrb = MemWriteM ? strb : 4'b0000;

  assign StallM         = alignedAccess & ~mem_ready & ~timeoutFire;
  assign bus_err        = timeoutFire;
  assign misaligned_err = access & misaligned & ~reset;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (alignedAccess && !mem_ready) nextState = WAIT;
      WAIT:    if (!alignedAccess || mem_ready || timeoutFire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // waitCnt counts cycles since the request was first presented, so the
  // abort lands on the TIMEOUT_CYCLES-th cycle of the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (nextState == WAIT)
        waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : CNT_W'(1);
      else
        waitCnt <= '0;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RES_ALU;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RES_ALU;
      RdW        <= '0;
    end else begin
      RegWriteW  <= RegWriteM & ~(access & misaligned) & ~timeoutFire;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= loadData;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
    end
  end

endmodule
